// File: rtl/cpu_multicycle_if.sv
// Memory-side bus of cpu_multicycle: instruction fetch and data access channels,
// each a req/ack handshake so that wait-state memories can stretch the access.
interface cpu_multicycle_if #(
  parameter int DATA_W  = 16,
  parameter int IADDR_W = 10,
  parameter int DADDR_W = 8
);
  logic               imem_req;
  logic [IADDR_W-1:0] imem_addr;
  logic [15:0]        imem_rdata;
  logic               imem_ack;

  logic               dmem_req;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               dmem_ack;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_ack,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/cpu_multicycle.sv
// Multi-cycle core for the 16-bit instruction set: FETCH, DECODE, EXECUTE and an
// optional MEM step, with instruction and data memories behind req/ack handshakes.
module cpu_multicycle #(
  parameter int DATA_W  = 16,
  parameter int IADDR_W = 10,
  parameter int DADDR_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  cpu_multicycle_if.master   mem,
  input  logic [2:0]         dbg_sel,
  output logic [DATA_W-1:0]  dbg_reg,
  output logic [15:0]        IR,
  output logic [IADDR_W-1:0] PC,
  output logic [3:0]         status,
  output logic               retire
);

  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, MEM} state_t;

  state_t            state;
  logic [DATA_W-1:0] rf [8];
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;

  logic [2:0] da, aa, ba;
  logic [3:0] fs;
  logic       mb, md, rw, mw, pl, jb, bc;

  // JMP shares bit 13 with the load flag; masking it keeps jumps out of MEM.
  always_comb begin
    da = IR[8:6];
    aa = IR[5:3];
    ba = IR[2:0];
    mb = IR[15];
    pl = IR[15] & IR[14];
    jb = IR[13];
    bc = IR[9];
    mw = IR[14] & ~IR[15];
    rw = ~IR[14];
    md = IR[13] & ~IR[14];
    fs = {IR[12:10], IR[9] & ~pl};
  end

  logic [DATA_W-1:0] muxb;
  logic [DATA_W-1:0] y_op;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] f;
  logic              flag_v, flag_c, flag_n, flag_z;

  always_comb begin
    muxb = mb ? {{(DATA_W-3){1'b0}}, IR[2:0]} : b_reg;
    case (fs[2:1])
      2'b00:   y_op = '0;
      2'b01:   y_op = muxb;
      2'b10:   y_op = ~muxb;
      default: y_op = '1;
    endcase
    sum    = {1'b0, a_reg} + {1'b0, y_op} + {{DATA_W{1'b0}}, fs[0]};
    f      = sum[DATA_W-1:0];
    flag_c = 1'b0;
    flag_v = 1'b0;
    if (!fs[3]) begin
      flag_c = sum[DATA_W];
      flag_v = (a_reg[DATA_W-1] == y_op[DATA_W-1]) && (f[DATA_W-1] != a_reg[DATA_W-1]);
    end else begin
      case (fs[2:0])
        3'b000:  f = a_reg & muxb;
        3'b001:  f = a_reg | muxb;
        3'b010:  f = a_reg ^ muxb;
        3'b011:  f = ~a_reg;
        3'b100:  f = muxb;
        3'b101:  f = muxb >> 1;
        3'b110:  f = muxb << 1;
        default: f = '0;
      endcase
    end
    flag_n = f[DATA_W-1];
    flag_z = (f == '0);
  end

  logic [IADDR_W-1:0] pc_inc;
  logic [IADDR_W-1:0] ad_ext;
  logic [IADDR_W-1:0] pc_next;

  always_comb begin
    pc_inc = PC + 1'b1;
    ad_ext = {{(IADDR_W-6){IR[8]}}, IR[8:6], IR[2:0]};
    if (!pl)
      pc_next = pc_inc;
    else if (jb)
      pc_next = a_reg[IADDR_W-1:0];
    else if (bc ? flag_n : flag_z)
      pc_next = PC + ad_ext;
    else
      pc_next = pc_inc;
  end

  // A memory instruction completes on the cycle its data ack is sampled.
  always_comb begin
    retire = ((state == EXECUTE) && !(mw || md)) ||
             ((state == MEM) && mem.dmem_req && mem.dmem_ack);
  end

  assign dbg_reg       = rf[dbg_sel];
  assign mem.imem_addr = PC;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= FETCH;
      PC             <= '0;
      IR             <= '0;
      status         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      mem.imem_req   <= 1'b0;
      mem.dmem_req   <= 1'b0;
      mem.dmem_we    <= 1'b0;
      mem.dmem_addr  <= '0;
      mem.dmem_wdata <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem.imem_req && mem.imem_ack) begin
            IR           <= mem.imem_rdata;
            mem.imem_req <= 1'b0;
            state        <= DECODE;
          end else begin
            mem.imem_req <= 1'b1;
          end
        end
        DECODE: begin
          a_reg <= rf[aa];
          b_reg <= rf[ba];
          state <= EXECUTE;
        end
        EXECUTE: begin
          status <= {flag_v, flag_c, flag_n, flag_z};
          if (rw && !md) rf[da] <= f;
          if (mw || md) begin
            mem.dmem_req   <= 1'b1;
            mem.dmem_we    <= mw;
            mem.dmem_addr  <= a_reg[DADDR_W-1:0];
            mem.dmem_wdata <= muxb;
            state          <= MEM;
          end else begin
            PC           <= pc_next;
            mem.imem_req <= 1'b1;
            state        <= FETCH;
          end
        end
        MEM: begin
          if (mem.dmem_req && mem.dmem_ack) begin
            if (md && rw) rf[da] <= mem.dmem_rdata;
            PC           <= pc_inc;
            mem.dmem_req <= 1'b0;
            mem.dmem_we  <= 1'b0;
            mem.imem_req <= 1'b1;
            state        <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: a small handshaking memory model feeds one
// instruction at a time and results are compared with hand-computed values.
module tb_cpu_multicycle;
  localparam int DW = 32;
  localparam int IW = 10;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    dbg_sel = 3'd0;
  logic [DW-1:0] dbg_reg;
  logic [15:0]   IR;
  logic [IW-1:0] PC;
  logic [3:0]    status;
  logic          retire;

  cpu_multicycle_if #(.DATA_W(DW), .IADDR_W(IW), .DADDR_W(AW)) mem ();

  cpu_multicycle #(.DATA_W(DW), .IADDR_W(IW), .DADDR_W(AW)) dut (
    .clock   (clock),
    .reset   (reset),
    .mem     (mem),
    .dbg_sel (dbg_sel),
    .dbg_reg (dbg_reg),
    .IR      (IR),
    .PC      (PC),
    .status  (status),
    .retire  (retire)
  );

  always #10 clock = ~clock;

  logic [DW-1:0] dmem [256];
  int checks   = 0;
  int failures = 0;

  int            r_cyc;
  logic [IW-1:0] r_faddr;
  bit            r_hold_err;
  logic          r_we;
  logic [AW-1:0] r_daddr;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkReg(input string tag, input int r, input logic [DW-1:0] exp);
    dbg_sel = r[2:0];
    #1;
    checkOutput(tag, dbg_reg, exp);
  endtask

  // Serves one instruction: answers fetch and data requests after the given
  // number of wait cycles and returns how many cycles passed until retire.
  task automatic applyStimulus(input logic [15:0] instr, input int iwait, input int dwait,
                               input bit abort_on_dreq);
    int icnt = 0;
    int dcnt = 0;
    bit done = 0;
    bit f_seen = 0;
    bit d_seen = 0;
    logic [DW-1:0] wd = '0;
    r_cyc = 0; r_faddr = '0; r_hold_err = 0; r_we = 1'b0; r_daddr = '0;
    while (!done && r_cyc < 40) begin
      @(negedge clock);
      r_cyc++;
      mem.imem_rdata = instr;
      if (mem.imem_req) begin
        if (!f_seen) begin
          f_seen  = 1;
          r_faddr = mem.imem_addr;
        end else if (mem.imem_addr !== r_faddr) r_hold_err = 1;
        mem.imem_ack = (icnt >= iwait);
        icnt++;
      end else begin
        if (f_seen && icnt <= iwait) r_hold_err = 1;
        mem.imem_ack = 1'b0;
      end
      if (mem.dmem_req) begin
        if (!d_seen) begin
          d_seen  = 1;
          r_we    = mem.dmem_we;
          r_daddr = mem.dmem_addr;
          wd      = mem.dmem_wdata;
        end else if (mem.dmem_we !== r_we || mem.dmem_addr !== r_daddr || mem.dmem_wdata !== wd)
          r_hold_err = 1;
        mem.dmem_rdata = dmem[mem.dmem_addr];
        mem.dmem_ack   = !abort_on_dreq && (dcnt >= dwait);
        if (mem.dmem_ack && mem.dmem_we) dmem[mem.dmem_addr] = mem.dmem_wdata;
        dcnt++;
        if (abort_on_dreq) done = 1;
      end else begin
        if (d_seen && dcnt <= dwait) r_hold_err = 1;
        mem.dmem_ack = 1'b0;
      end
      #1;
      if (retire) done = 1;
    end
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  task automatic releaseReset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mem.imem_ack = 1'b0; mem.imem_rdata = '0;
    mem.dmem_ack = 1'b0; mem.dmem_rdata = '0;
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    dmem[0] = 32'hDEAD1234;

    repeat (3) @(negedge clock);
    checkOutput("rst_pc", PC, 0);
    checkOutput("rst_ir", IR, 0);
    checkOutput("rst_status", status, 0);
    checkOutput("rst_imem_req", mem.imem_req, 0);
    checkOutput("rst_dmem_req", mem.dmem_req, 0);
    checkOutput("rst_dmem_we", mem.dmem_we, 0);
    checkOutput("rst_retire", retire, 0);
    for (int r = 0; r < 8; r++) checkReg("rst_reg", r, 0);

    reset = 1'b1;
    @(negedge clock);
    checkOutput("rel_imem_req", mem.imem_req, 1);
    checkOutput("rel_imem_addr", mem.imem_addr, 0);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checkOutput("midfetch_imem_req", mem.imem_req, 0);
    checkOutput("midfetch_pc", PC, 0);
    checkOutput("midfetch_status", status, 0);
    releaseReset();

    applyStimulus(16'h8445, 0, 0, 0);
    checkOutput("adi_cycles", r_cyc, 3);
    checkOutput("adi_faddr", r_faddr, 0);
    settle();
    checkReg("adi_r1", 1, 5);
    checkOutput("adi_pc", PC, 1);
    checkOutput("adi_ir", IR, 16'h8445);
    checkOutput("adi_status", status, 4'b0000);

    applyStimulus(16'h0489, 0, 0, 0);
    checkOutput("add_cycles", r_cyc, 3);
    checkOutput("add_faddr", r_faddr, 1);
    settle();
    checkReg("add_r2", 2, 10);
    checkOutput("add_status", status, 4'b0000);

    applyStimulus(16'h8504, 3, 0, 0);
    checkOutput("iwait_cycles", r_cyc, 6);
    checkOutput("iwait_hold", r_hold_err, 0);
    checkOutput("iwait_faddr", r_faddr, 2);
    settle();
    checkReg("iwait_r4", 4, 4);

    applyStimulus(16'h1D04, 0, 0, 0);
    settle();
    checkReg("shl1_r4", 4, 8);
    applyStimulus(16'h1D04, 0, 0, 0);
    settle();
    checkReg("shl2_r4", 4, 16);

    applyStimulus(16'h20C0, 0, 0, 0);
    checkOutput("ld0_cycles", r_cyc, 4);
    checkOutput("ld0_we", r_we, 0);
    settle();
    checkReg("ld0_r3", 3, 32'hDEAD1234);
    checkOutput("ld0_status", status, 4'b0001);
    checkOutput("ld0_pc", PC, 6);

    applyStimulus(16'h4023, 0, 2, 0);
    checkOutput("st_cycles", r_cyc, 6);
    checkOutput("st_we", r_we, 1);
    checkOutput("st_addr", r_daddr, 8'h10);
    checkOutput("st_hold", r_hold_err, 0);
    settle();
    checkOutput("st_mem", dmem[16], 32'hDEAD1234);
    checkOutput("st_pc", PC, 7);

    applyStimulus(16'h2160, 0, 2, 0);
    checkOutput("ld_cycles", r_cyc, 6);
    checkOutput("ld_we", r_we, 0);
    checkOutput("ld_hold", r_hold_err, 0);
    settle();
    checkReg("ld_r5", 5, 32'hDEAD1234);
    checkOutput("ld_pc", PC, 8);

    applyStimulus(16'h0B81, 0, 0, 0);
    settle();
    checkReg("sub_r6", 6, 32'hFFFFFFFB);
    checkOutput("sub_status", status, 4'b0010);

    applyStimulus(16'h21E0, 0, 5, 1);
    checkOutput("abort_dreq_seen", mem.dmem_req, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_dmem_req", mem.dmem_req, 0);
    checkOutput("abort_pc", PC, 0);
    checkReg("abort_r7", 7, 0);
    checkReg("abort_r3", 3, 0);
    releaseReset();

    applyStimulus(16'hC1C7, 0, 0, 0);
    checkOutput("brz_faddr", r_faddr, 0);
    checkOutput("brz_cycles", r_cyc, 3);
    settle();
    checkOutput("brz_pc_wrap", PC, 10'h3FF);
    checkOutput("brz_status", status, 4'b0001);

    applyStimulus(16'h8441, 0, 0, 0);
    checkOutput("wrap_faddr", r_faddr, 10'h3FF);
    settle();
    checkOutput("wrap_pc", PC, 0);
    checkReg("wrap_r1", 1, 1);

    applyStimulus(16'hC1CF, 0, 0, 0);
    settle();
    checkOutput("brz_nt_pc", PC, 1);
    checkOutput("brz_nt_status", status, 4'b0000);

    applyStimulus(16'h8486, 0, 0, 0);
    applyStimulus(16'hE010, 0, 0, 0);
    checkOutput("jmp_faddr", r_faddr, 2);
    checkOutput("jmp_cycles", r_cyc, 3);
    settle();
    checkOutput("jmp_pc", PC, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
